// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: restoring divide of the significands, then normalise and flag.
// Latency: out_valid rises 26 edges after capture for normal operands, 1 edge after for zero operands.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen high.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_1,
  input  logic        sign_2,
  input  logic [7:0]  exp_1,
  input  logic [7:0]  exp_2,
  input  logic [22:0] man_1,
  input  logic [22:0] man_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        final_sign,
  output logic [7:0]  final_exp,
  output logic [22:0] final_man,
  output logic [2:0]  flags
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t      state;
  logic        sign_1_r;
  logic        sign_2_r;
  logic [7:0]  exp_1_r;
  logic [7:0]  exp_2_r;
  logic [23:0] div_r;     // divisor significand B
  logic [24:0] rem_r;     // partial remainder, always < 2*B after the shift
  logic [24:0] q_r;       // quotient bits, MSB first
  logic [4:0]  cnt_r;     // CALC iteration index 0..24

  logic        rem_ge;
  logic [24:0] rem_next;
  logic [24:0] rem_shift;
  logic [9:0]  e_calc;

  // One restoring step: subtract when possible, then shift for the next quotient bit
  always_comb begin
    rem_ge    = (rem_r >= {1'b0, div_r});
    rem_next  = rem_ge ? (rem_r - {1'b0, div_r}) : rem_r;
    rem_shift = rem_next << 1;
  end

  // Unbiased exponent difference rebiased; 10 bits two's complement covers -127..381
  always_comb begin
    e_calc = {2'b00, exp_1_r} - {2'b00, exp_2_r} + 10'd126 + {9'd0, q_r[24]};
  end

  // Control FSM with the datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      final_sign <= 1'b0;
      final_exp  <= 8'd0;
      final_man  <= 23'd0;
      flags      <= 3'b000;
      sign_1_r   <= 1'b0;
      sign_2_r   <= 1'b0;
      exp_1_r    <= 8'd0;
      exp_2_r    <= 8'd0;
      div_r      <= 24'd0;
      rem_r      <= 25'd0;
      q_r        <= 25'd0;
      cnt_r      <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_1_r <= sign_1;
            sign_2_r <= sign_2;
            exp_1_r  <= exp_1;
            exp_2_r  <= exp_2;
            rem_r    <= {1'b0, |exp_1, man_1};
            div_r    <= {|exp_2, man_2};
            q_r      <= 25'd0;
            cnt_r    <= 5'd0;
            in_ready <= 1'b0;
            // A zero operand needs no division; go straight to result formation
            if (exp_1 == 8'd0 || exp_2 == 8'd0) state <= NORM;
            else                                 state <= CALC;
          end
        end

        CALC: begin
          q_r   <= {q_r[23:0], rem_ge};
          rem_r <= rem_shift;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd24) state <= NORM;
        end

        NORM: begin
          final_sign <= sign_1_r ^ sign_2_r;
          if (exp_2_r == 8'd0) begin
            final_exp <= 8'hFF;
            final_man <= 23'd0;
            flags     <= 3'b001;
          end else if (exp_1_r == 8'd0) begin
            final_exp <= 8'h00;
            final_man <= 23'd0;
            flags     <= 3'b000;
          end else if ($signed(e_calc) >= 10'sd255) begin
            final_exp <= 8'hFF;
            final_man <= 23'd0;
            flags     <= 3'b010;
          end else if ($signed(e_calc) <= 10'sd0) begin
            final_exp <= 8'h00;
            final_man <= 23'd0;
            flags     <= 3'b100;
          end else begin
            final_exp <= e_calc[7:0];
            // Quotient lies in [0.5, 2); drop the leading one, truncate the rest
            final_man <= q_r[24] ? q_r[23:1] : q_r[22:0];
            flags     <= 3'b000;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed literal cases, backpressure, mid-op reset, then randomized traffic.
// Expected results come from an arithmetic model (integer division of scaled significands).
// A monitor compares every cycle out_valid is high and checks capture-to-valid latency.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_1 = 1'b0, sign_2 = 1'b0;
  logic [7:0]  exp_1 = 8'd0, exp_2 = 8'd0;
  logic [22:0] man_1 = 23'd0, man_2 = 23'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        final_sign;
  logic [7:0]  final_exp;
  logic [22:0] final_man;
  logic [2:0]  flags;

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_1(sign_1), .sign_2(sign_2), .exp_1(exp_1), .exp_2(exp_2),
    .man_1(man_1), .man_2(man_2), .out_valid(out_valid), .out_ready(out_ready),
    .final_sign(final_sign), .final_exp(final_exp), .final_man(final_man), .flags(flags)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [34:0] res;
    int          cap;
    int          lat;
    bit          seen;
  } exp_t;
  exp_t expq[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: quotient = floor(A*2^24/B) on plain integers, then the rebias and flag rules
  function automatic logic [34:0] model(input logic s1, input logic [7:0] e1, input logic [22:0] m1,
                                        input logic s2, input logic [7:0] e2, input logic [22:0] m2);
    longint a, b, qq;
    int e;
    logic sg;
    logic [22:0] man;
    sg = s1 ^ s2;
    if (e2 == 8'd0) return {sg, 8'hFF, 23'd0, 3'b001};
    if (e1 == 8'd0) return {sg, 8'h00, 23'd0, 3'b000};
    a  = longint'({1'b1, m1});
    b  = longint'({1'b1, m2});
    qq = (a << 24) / b;
    e  = int'(e1) - int'(e2) + 126 + ((qq >= 64'sd16777216) ? 1 : 0);
    if (e >= 255) return {sg, 8'hFF, 23'd0, 3'b010};
    if (e <= 0)   return {sg, 8'h00, 23'd0, 3'b100};
    if (qq >= 64'sd16777216) man = 23'((qq >> 1) & 64'h7FFFFF);
    else                     man = 23'(qq & 64'h7FFFFF);
    return {sg, e[7:0], man, 3'b000};
  endfunction

  function automatic logic [7:0] rand_exp();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'd0;
    if (r == 1) return 8'($urandom_range(1, 3));
    if (r == 2) return 8'($urandom_range(250, 254));
    return 8'($urandom_range(1, 254));
  endfunction

  // Compare process: result and busy handshake every cycle a result is presented
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got out_valid=1 expected no pending result");
      end else begin
        check("result", 64'({final_sign, final_exp, final_man, flags}), 64'(expq[0].res));
        check("in_ready_busy", 64'(in_ready), 64'd0);
        if (!expq[0].seen) begin
          expq[0].seen = 1'b1;
          check("latency", 64'(cyc - expq[0].cap), 64'(expq[0].lat));
        end
      end
    end
  end

  // Retire the expectation on the handshake edge
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
  end

  // Random downstream readiness during the randomized phase
  always @(posedge clk) begin
    if (rand_rdy) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic s1, input logic [7:0] e1, input logic [22:0] m1,
                       input logic s2, input logic [7:0] e2, input logic [22:0] m2, input bit junk);
    exp_t e;
    int n;
    @(negedge clk);
    sign_1 = s1; exp_1 = e1; man_1 = m1;
    sign_2 = s2; exp_2 = e2; man_2 = m2;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.res  = model(s1, e1, m1, s2, e2, m2);
    e.cap  = cyc;
    e.lat  = (e1 == 8'd0 || e2 == 8'd0) ? 1 : 26;
    e.seen = 1'b0;
    expq.push_back(e);
    // While busy, keep offering different operands; they must be ignored
    if (junk && e.lat == 26) begin
      sign_1 = 1'($urandom); exp_1 = rand_exp(); man_1 = 23'($urandom);
      sign_2 = 1'($urandom); exp_2 = rand_exp(); man_2 = 23'($urandom);
      repeat (20) @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL valid_timeout: got out_valid=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("accept_valid_low", 64'(out_valid), 64'd0);
    check("accept_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  task automatic check_res(input string name, input logic s, input logic [7:0] e,
                           input logic [22:0] m, input logic [2:0] f);
    check({name, "_sign"}, 64'(final_sign), 64'(s));
    check({name, "_exp"}, 64'(final_exp), 64'(e));
    check({name, "_man"}, 64'(final_man), 64'(m));
    check({name, "_flags"}, 64'(flags), 64'(f));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected completion before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] snap;
    logic        hold_ok;
    int          n;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check_res("rst", 1'b0, 8'd0, 23'd0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the model with hand-computed values
    check("pin_6_2", 64'(model(0, 8'd129, 23'h400000, 0, 8'd128, 23'd0)),
          64'({1'b0, 8'd128, 23'h400000, 3'b000}));
    check("pin_1_1p5", 64'(model(0, 8'd127, 23'd0, 0, 8'd127, 23'h400000)),
          64'({1'b0, 8'd126, 23'h2AAAAA, 3'b000}));
    check("pin_div0", 64'(model(1, 8'd128, 23'h400000, 0, 8'd0, 23'd0)),
          64'({1'b1, 8'hFF, 23'd0, 3'b001}));

    // 6.0 / 2.0
    issue(0, 8'd129, 23'h400000, 0, 8'd128, 23'd0, 0);
    wait_valid();
    if (expq.size() > 0) check("lat_6_2", 64'(cyc - expq[0].cap), 64'd26);
    check_res("d6_2", 1'b0, 8'd128, 23'h400000, 3'b000);
    accept();

    // 1.0 / 1.5
    issue(0, 8'd127, 23'd0, 0, 8'd127, 23'h400000, 0);
    wait_valid();
    check_res("d1_1p5", 1'b0, 8'd126, 23'h2AAAAA, 3'b000);
    accept();

    // -3.0 / 0
    issue(1, 8'd128, 23'h400000, 0, 8'd0, 23'd0, 0);
    wait_valid();
    if (expq.size() > 0) check("lat_div0", 64'(cyc - expq[0].cap), 64'd1);
    check_res("div0", 1'b1, 8'hFF, 23'd0, 3'b001);
    accept();

    // Overflow and underflow
    issue(0, 8'd254, 23'd0, 0, 8'd1, 23'd0, 0);
    wait_valid();
    check_res("ovf", 1'b0, 8'hFF, 23'd0, 3'b010);
    accept();
    issue(0, 8'd1, 23'd0, 1, 8'd254, 23'd0, 0);
    wait_valid();
    check_res("unf", 1'b1, 8'h00, 23'd0, 3'b100);
    accept();

    // Backpressure: result must hold for 10 cycles with out_ready low
    issue(1, 8'd140, 23'h123456, 0, 8'd120, 23'h654321, 0);
    wait_valid();
    snap = {final_sign, final_exp, final_man, flags};
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({final_sign, final_exp, final_man, flags} !== snap || in_ready !== 1'b0 || out_valid !== 1'b1)
        hold_ok = 1'b0;
    end
    check("hold_stable", 64'(hold_ok), 64'd1);
    accept();

    // Reset pulsed during CALC iteration 12
    issue(0, 8'd129, 23'h400000, 0, 8'd128, 23'd0, 0);
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) hold_ok = 1'b0;
    end
    check("flushed_no_valid", 64'(hold_ok), 64'd1);
    issue(0, 8'd129, 23'h400000, 0, 8'd128, 23'd0, 0);
    wait_valid();
    check_res("after_rst", 1'b0, 8'd128, 23'h400000, 3'b000);
    accept();

    // Randomized traffic with random downstream readiness
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      issue(1'($urandom), rand_exp(), 23'($urandom), 1'($urandom), rand_exp(), 23'($urandom), 1);
    end
    n = 0;
    while (expq.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
    end
    rand_rdy = 1'b0;
    #5;
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with no other clock or reset inputs.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset; assertion SHALL clear all state immediately, without waiting for a clock edge.
REQ-004 Port in_valid, input, 1: operand pair present.
REQ-005 Port in_ready, output, 1: block can accept operands; high only in IDLE.
REQ-006 Port sign_1 / sign_2, input, 1 each: dividend / divisor sign.
REQ-007 Port exp_1 / exp_2, input, 8 each: dividend / divisor biased exponent (bias 127).
REQ-008 Port man_1 / man_2, input, 23 each: dividend / divisor fraction field.
REQ-009 Port out_valid, output, 1: result valid; held until accepted.
REQ-010 Port out_ready, input, 1: downstream accepts result.
REQ-011 Port final_sign, output, 1: quotient sign.
REQ-012 Port final_exp, output, 8: quotient biased exponent.
REQ-013 Port final_man, output, 23: quotient fraction.
REQ-014 Port flags, output, 3: bit0 divide-by-zero, bit1 overflow, bit2 underflow.

Function
REQ-015 The state machine SHALL have four states, IDLE, CALC, NORM and DONE, with IDLE as the reset state.
REQ-016 Capture: the operands SHALL be registered at an edge where in_valid and in_ready are both high.
REQ-017 Significands: A = {|exp_1, man_1} and B = {|exp_2, man_2}, each 24 bits; inputs with exp = 0 are treated as zero; denormals are not supported.
REQ-018 Normal path: the block SHALL go IDLE -> CALC on capture.
REQ-019 CALC SHALL run a restoring division, one quotient bit per cycle, for exactly 25 cycles, producing q = floor(A * 2^24 / B) as 25 bits.
REQ-020 After the 25th CALC cycle the block SHALL go to NORM.
REQ-021 Special path: if exp_1 == 0 or exp_2 == 0 at capture, the block SHALL go IDLE -> NORM directly and skip CALC.
REQ-022 NORM SHALL form the exponent as a 10-bit signed value E = exp_1 - exp_2 + 126 + q[24].
REQ-023 NORM mantissa: final_man SHALL be q[23:1] when q[24] = 1, and q[22:0] otherwise; truncation, no rounding.
REQ-024 final_sign SHALL equal sign_1 XOR sign_2 in every case, including the special cases.
REQ-025 Divide-by-zero (exp_2 == 0): final_exp = 8'hFF, final_man = 0, flags = 3'b001; this takes priority over exp_1 == 0.
REQ-026 Zero dividend (exp_1 == 0, exp_2 != 0): final_exp = 0, final_man = 0, flags = 3'b000.
REQ-027 Overflow (E >= 255): final_exp = 8'hFF, final_man = 0, flags = 3'b010.
REQ-028 Underflow (E <= 0): final_exp = 0, final_man = 0, flags = 3'b100.
REQ-029 NORM SHALL register all result outputs and go to DONE.
REQ-030 In DONE, out_valid SHALL be 1 and all outputs SHALL be held stable.
REQ-031 On out_valid and out_ready both high, the block SHALL go DONE -> IDLE, and out_valid SHALL fall after that edge.
REQ-032 Latency, normal path: if capture occurs at edge T, out_valid SHALL be high after edge T+26.
REQ-033 Latency, special path: if capture occurs at edge T, out_valid SHALL be high after edge T+1.
REQ-034 No overlap: in_ready SHALL be low in CALC, NORM and DONE, and in_valid SHALL be ignored there.
REQ-035 Back-to-back: the next capture SHALL be possible no earlier than the edge after the DONE -> IDLE edge.
REQ-036 Result outputs SHALL keep the last result until the next NORM.

Reset
REQ-037 When rst_n = 0, the block SHALL asynchronously enter IDLE.
REQ-038 When rst_n = 0, out_valid, final_sign, final_exp, final_man, flags, the quotient register and the iteration counter SHALL all be 0, and in_ready SHALL be 1.
REQ-039 If rst_n falls mid-CALC or mid-DONE, the operation in flight SHALL be discarded and no out_valid SHALL be produced for it.
REQ-040 After rst_n is released, the first capture SHALL be possible at the first rising edge with in_valid = 1.

Verification
REQ-041 The bench SHALL check that 6.0 / 2.0 (exp_1 = 129, man_1 = 0x400000, exp_2 = 128, man_2 = 0) gives final_exp = 128, final_man = 0x400000, flags = 0, with out_valid 26 edges after capture.
REQ-042 The bench SHALL check that 1.0 / 1.5 (exp_1 = 127, man_1 = 0, exp_2 = 127, man_2 = 0x400000) gives final_exp = 126, final_man = 0x2AAAAA.
REQ-043 The bench SHALL check that -3.0 / 0 (sign_1 = 1, exp_1 = 128, man_1 = 0x400000, exp_2 = 0) gives final_sign = 1, final_exp = 0xFF, final_man = 0, flags = 3'b001, with out_valid 1 edge after capture.
REQ-044 The bench SHALL check that exp_1 = 254 over exp_2 = 1 (both man 0) gives overflow flags = 3'b010 and final_exp = 0xFF, and that exp_1 = 1 over exp_2 = 254 gives underflow flags = 3'b100 and final_exp = 0.
REQ-045 The bench SHALL check that, with out_ready held 0 for 10 cycles in DONE, outputs stay stable and in_ready stays 0, and that a DONE -> IDLE transition occurs on the first cycle with out_ready = 1.
REQ-046 The bench SHALL check that rst_n pulsed low at CALC iteration 12 forces out_valid = 0 and in_ready = 1 immediately, and that a new 6.0 / 2.0 issued afterwards completes correctly.
